// File: rtl/div_op_sequencer_pkg.sv
// Shared types for the divider operand sequencer: FSM state encoding, debug view
// and the quotient pattern reported for a zero divisor.
package div_seq_pkg;

  localparam int STATE_W = 3;
  localparam int MAX_P   = 64;

  // All-ones quotient marks a divide-by-zero result; sliced down to P bits by users.
  localparam logic [MAX_P-1:0] DZ_QUOTIENT = '1;

  typedef enum logic [STATE_W-1:0] {
    IDLE  = 3'd0,
    CLR   = 3'd1,
    START = 3'd2,
    WAIT  = 3'd3,
    DZ    = 3'd4,
    OUT   = 3'd5
  } state_e;

  typedef struct packed {
    state_e      state;
    logic [15:0] wait_cnt;
  } dbg_t;

endpackage

// File: rtl/div_op_sequencer_if.sv
// Operand, result and divider-side signals of div_op_sequencer. Handshakes: a
// transfer happens on a clock edge where valid && ready; valid holds until then.
interface div_op_sequencer_if #(
  parameter int N = 8,
  parameter int P = 8
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_x;
  logic [N-1:0] in_y;
  logic         out_valid;
  logic         out_ready;
  logic [P-1:0] out_quotient;
  logic [P-1:0] out_remainder;
  logic         out_dz;
  logic         busy;
  logic         div_reset;
  logic         div_start;
  logic [N-1:0] div_x;
  logic [N-1:0] div_y;
  logic         div_done;
  logic [P-1:0] div_quotient;
  logic [P-1:0] div_remainder;
`ifdef DIV_TIMEOUT_EN
  logic         out_timeout;
`endif

  modport slave (
`ifdef DIV_TIMEOUT_EN
    output out_timeout,
`endif
    input  in_valid, in_x, in_y, out_ready, div_done, div_quotient, div_remainder,
    output in_ready, out_valid, out_quotient, out_remainder, out_dz, busy,
    output div_reset, div_start, div_x, div_y
  );

  modport master (
`ifdef DIV_TIMEOUT_EN
    input  out_timeout,
`endif
    output in_valid, in_x, in_y, out_ready, div_done, div_quotient, div_remainder,
    input  in_ready, out_valid, out_quotient, out_remainder, out_dz, busy,
    input  div_reset, div_start, div_x, div_y
  );

endinterface

// File: rtl/div_op_sequencer_op_fifo.sv
// Small operand FIFO; DEPTH must be a power of two so the pointers wrap for free.
module op_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic [W-1:0]               i_wdata,
  output logic [W-1:0]               o_rdata,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_full,
  output logic                       o_empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_rdata   = r_mem[r_rd_ptr];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      // Push and pop together leave the occupancy unchanged.
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
  end

endmodule

// File: rtl/div_op_sequencer.sv
// Sequences buffered (x, y) pairs through an external restoring divider and returns
// quotient/remainder; zero divisors bypass the divider. DIV_TIMEOUT_EN adds a WAIT abort.
module div_op_sequencer
  import div_seq_pkg::*;
#(
  parameter int N       = 8,
  parameter int P       = 8,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                clk,
  input  logic                reset,
  div_op_sequencer_if.slave   bus,
  output dbg_t                o_dbg
);
  localparam int CW   = $clog2(DEPTH) + 1;
  localparam int TO_W = $clog2(TIMEOUT) + 1;

  state_e          r_state;
  state_e          w_next;
  logic [N-1:0]    r_op_x;
  logic [N-1:0]    r_op_y;
  logic [P-1:0]    r_quot;
  logic [P-1:0]    r_rem;
  logic            r_valid;
  logic            r_dz;
  logic [TO_W-1:0] r_wait_cnt;
  logic            w_push;
  logic            w_pop;
  logic            w_full;
  logic            w_empty;
  logic [CW-1:0]   w_count;
  logic [2*N-1:0]  w_head;
  logic [N-1:0]    w_head_x;
  logic [N-1:0]    w_head_y;
  logic            w_timeout_hit;

  assign w_push   = bus.in_valid && bus.in_ready;
  assign w_pop    = (r_state == IDLE) && !w_empty;
  assign w_head_x = w_head[2*N-1:N];
  assign w_head_y = w_head[N-1:0];

  op_fifo #(.W(2*N), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata ({bus.in_x, bus.in_y}),
    .o_rdata (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

`ifdef DIV_TIMEOUT_EN
  assign w_timeout_hit = (r_wait_cnt == TO_W'(TIMEOUT - 1));
`else
  assign w_timeout_hit = 1'b0;
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (!w_empty) w_next = (w_head_y == '0) ? DZ : CLR;
      CLR:     w_next = START;
      START:   w_next = WAIT;
      WAIT:    if (bus.div_done || w_timeout_hit) w_next = OUT;
      DZ:      w_next = OUT;
      OUT:     if (bus.out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_op_x <= '0;
      r_op_y <= '0;
    end else if (w_pop) begin
      r_op_x <= w_head_x;
      r_op_y <= w_head_y;
    end
  end

  // Counts cycles spent in WAIT; saturates so a stuck divider cannot wrap it.
  always_ff @(posedge clk) begin
    if (!reset || r_state != WAIT) r_wait_cnt <= '0;
    else if (r_wait_cnt != '1)     r_wait_cnt <= r_wait_cnt + TO_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_valid <= 1'b0;
      r_dz    <= 1'b0;
      r_quot  <= '0;
      r_rem   <= '0;
    end else begin
      case (r_state)
        WAIT: begin
          if (bus.div_done) begin
            r_quot  <= bus.div_quotient;
            r_rem   <= bus.div_remainder;
            r_dz    <= 1'b0;
            r_valid <= 1'b1;
          end else if (w_timeout_hit) begin
            r_quot  <= '0;
            r_rem   <= '0;
            r_dz    <= 1'b0;
            r_valid <= 1'b1;
          end
        end
        DZ: begin
          r_quot  <= DZ_QUOTIENT[P-1:0];
          r_rem   <= P'(r_op_x);
          r_dz    <= 1'b1;
          r_valid <= 1'b1;
        end
        OUT:     if (bus.out_ready) r_valid <= 1'b0;
        default: ;
      endcase
    end
  end

`ifdef DIV_TIMEOUT_EN
  logic r_timeout;

  always_ff @(posedge clk) begin
    if (!reset) r_timeout <= 1'b0;
    else if (r_state == WAIT && !bus.div_done && w_timeout_hit) r_timeout <= 1'b1;
    else if (r_state == OUT && bus.out_ready) r_timeout <= 1'b0;
  end

  assign bus.out_timeout = r_timeout;
`endif

  assign bus.in_ready      = reset && !w_full;
  assign bus.out_valid     = r_valid;
  assign bus.out_quotient  = r_quot;
  assign bus.out_remainder = r_rem;
  assign bus.out_dz        = r_dz;
  assign bus.busy          = (r_state != IDLE) || (w_count != '0);
  assign bus.div_reset     = !reset || (r_state == CLR);
  assign bus.div_start     = (r_state == START);
  assign bus.div_x         = r_op_x;
  assign bus.div_y         = r_op_y;

  assign o_dbg.state    = r_state;
  assign o_dbg.wait_cnt = 16'(r_wait_cnt);

endmodule

// File: tb/tb_div_op_sequencer.sv
// Bench for div_op_sequencer with a behavioural divider model; define DIV_TIMEOUT_EN
// on both bench and RTL to exercise the WAIT abort.
module tb_div_op_sequencer;
  import div_seq_pkg::*;

  localparam int N       = 8;
  localparam int P       = 8;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 64;
  localparam int DIV_LAT = 8;
  localparam int EW      = 2*P + 2;

  typedef struct {
    logic [N-1:0] x;
    logic [N-1:0] y;
    logic [P-1:0] q;
    logic [P-1:0] r;
    logic         dz;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  div_op_sequencer_if #(.N(N), .P(P)) bus ();
  dbg_t dbg;

  div_op_sequencer #(.N(N), .P(P), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .o_dbg (dbg)
  );

  logic act_to;
`ifdef DIV_TIMEOUT_EN
  assign act_to = bus.out_timeout;
`else
  assign act_to = 1'b0;
`endif

  // Divider model: start sampled on an edge, done visible DIV_LAT edges later, so
  // DIV_LAT+1 clocks counting the start cycle itself. done is sticky until div_reset.
  logic [4:0] div_cnt;
  logic       div_hang = 1'b0;
  always @(posedge clk) begin
    if (bus.div_reset) begin
      bus.div_done <= 1'b0;
      div_cnt      <= '0;
    end else if (bus.div_start) begin
      div_cnt <= 5'(DIV_LAT);
    end else if (div_cnt != 0) begin
      div_cnt <= div_cnt - 5'd1;
      if (div_cnt == 5'd1 && !div_hang) begin
        bus.div_done      <= 1'b1;
        bus.div_quotient  <= P'(bus.div_x / bus.div_y);
        bus.div_remainder <= P'(bus.div_x % bus.div_y);
      end
    end
  end

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  int start_cnt = 0;
  int clr_cnt = 0;
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] cur_exp;
  logic [EW-1:0] mon_e;
  logic [EW-1:0] mon_a;
  vec_t tbl[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [EW-1:0] pk(input logic [P-1:0] q, input logic [P-1:0] r,
                                       input logic dz, input logic to);
    return {q, r, dz, to};
  endfunction

  function automatic logic [EW-1:0] model(input logic [N-1:0] x, input logic [N-1:0] y);
    if (y == 0) return pk('1, P'(x), 1'b1, 1'b0);
    return pk(P'(x / y), P'(x % y), 1'b0, 1'b0);
  endfunction

  always @(negedge clk) begin
    if (reset) begin
      if (bus.in_valid && bus.in_ready) exp_q.push_back(cur_exp);
      if (bus.out_valid && bus.out_ready) begin
        mon_a = {bus.out_quotient, bus.out_remainder, bus.out_dz, act_to};
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL result_unexpected: got %0h expected none", mon_a);
        end else begin
          mon_e = exp_q.pop_front();
          check("result", 32'(mon_a), 32'(mon_e));
        end
      end
      if (bus.div_start) start_cnt++;
      if (bus.div_reset) clr_cnt++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_op(input logic [N-1:0] x, input logic [N-1:0] y, input logic [EW-1:0] e);
    int t = 0;
    bus.in_x     = x;
    bus.in_y     = y;
    cur_exp      = e;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && t < 400) begin
      @(posedge clk); #1;
      t++;
    end
    check("push_accepted", 32'(bus.in_ready), 32'd1);
    if (bus.in_ready) begin
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic drain(input int limit);
    int t = 0;
    while ((exp_q.size() != 0 || bus.busy) && t < limit) begin
      @(posedge clk); #1;
      t++;
    end
    check("drain_in_time", 32'(t < limit), 32'd1);
    exp_q.delete();
  endtask

  task automatic wait_valid(input int limit);
    int t = 0;
    while (!bus.out_valid && t < limit) begin
      @(posedge clk); #1;
      t++;
    end
    check("valid_in_time", 32'(bus.out_valid), 32'd1);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  // ---------------- main sequence ----------------
  initial begin
    int n;
    int t;
    bit stream_done;
    bus.in_valid  = 1'b0;
    bus.in_x      = '0;
    bus.in_y      = '0;
    bus.out_ready = 1'b0;
    cur_exp       = '0;

    tbl[0]  = '{8'd100, 8'd7,   8'd14,  8'd2,   1'b0};
    tbl[1]  = '{8'd55,  8'd0,   8'hFF,  8'd55,  1'b1};
    tbl[2]  = '{8'd200, 8'd9,   8'd22,  8'd2,   1'b0};
    tbl[3]  = '{8'd17,  8'd17,  8'd1,   8'd0,   1'b0};
    tbl[4]  = '{8'd0,   8'd5,   8'd0,   8'd0,   1'b0};
    tbl[5]  = '{8'd255, 8'd1,   8'd255, 8'd0,   1'b0};
    tbl[6]  = '{8'd9,   8'd4,   8'd2,   8'd1,   1'b0};
    tbl[7]  = '{8'd0,   8'd0,   8'hFF,  8'd0,   1'b1};
    tbl[8]  = '{8'd250, 8'd16,  8'd15,  8'd10,  1'b0};
    tbl[9]  = '{8'd13,  8'd200, 8'd0,   8'd13,  1'b0};
    tbl[10] = '{8'd255, 8'd255, 8'd1,   8'd0,   1'b0};
    tbl[11] = '{8'd128, 8'd0,   8'hFF,  8'd128, 1'b1};

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_state",     32'(dbg.state),         32'(IDLE));
    check("rst_out_valid", 32'(bus.out_valid),     32'd0);
    check("rst_quotient",  32'(bus.out_quotient),  32'd0);
    check("rst_remainder", 32'(bus.out_remainder), 32'd0);
    check("rst_dz",        32'(bus.out_dz),        32'd0);
    check("rst_div_start", 32'(bus.div_start),     32'd0);
    check("rst_div_reset", 32'(bus.div_reset),     32'd1);
    check("rst_in_ready",  32'(bus.in_ready),      32'd0);
    check("rst_busy",      32'(bus.busy),          32'd0);
`ifdef DIV_TIMEOUT_EN
    check("rst_timeout",   32'(bus.out_timeout),   32'd0);
`endif
    reset = 1'b1;
    @(posedge clk); #1;
    check("idle_in_ready",  32'(bus.in_ready),  32'd1);
    check("idle_div_reset", 32'(bus.div_reset), 32'd0);

    // Table vectors, one at a time, consumer always ready
    bus.out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      start_cnt = 0;
      clr_cnt   = 0;
      push_op(tbl[i].x, tbl[i].y, pk(tbl[i].q, tbl[i].r, tbl[i].dz, 1'b0));
      drain(200);
      check("start_pulses", 32'(start_cnt), 32'(tbl[i].y != 0));
      check("clr_pulses",   32'(clr_cnt),   32'(tbl[i].y != 0));
      check("back_to_idle", 32'(dbg.state), 32'(IDLE));
    end

    // Latency: zero divisor valid 2 edges after the IDLE/pop cycle begins
    bus.in_x = 8'd55; bus.in_y = 8'd0; cur_exp = pk(8'hFF, 8'd55, 1'b1, 1'b0);
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    n = 0;
    while (!bus.out_valid && n < 40) begin @(posedge clk); #1; n++; end
    check("dz_latency", 32'(n), 32'd2);
    drain(50);

    // Latency: non-zero divisor valid 3 + (DIV_LAT+1) edges later
    bus.in_x = 8'd100; bus.in_y = 8'd7; cur_exp = pk(8'd14, 8'd2, 1'b0, 1'b0);
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    n = 0;
    while (!bus.out_valid && n < 40) begin @(posedge clk); #1; n++; end
    check("div_latency", 32'(n), 32'(3 + DIV_LAT + 1));
    drain(50);

    // Capacity: one in flight plus DEPTH buffered while the consumer stalls
    bus.out_ready = 1'b0;
    push_op(8'd200, 8'd9,  pk(8'd22,  8'd2, 1'b0, 1'b0));
    push_op(8'd17,  8'd17, pk(8'd1,   8'd0, 1'b0, 1'b0));
    push_op(8'd0,   8'd5,  pk(8'd0,   8'd0, 1'b0, 1'b0));
    push_op(8'd255, 8'd1,  pk(8'd255, 8'd0, 1'b0, 1'b0));
    push_op(8'd30,  8'd4,  pk(8'd7,   8'd2, 1'b0, 1'b0));
    wait_valid(60);
    repeat (3) @(posedge clk);
    #1;
    check("full_in_ready",  32'(bus.in_ready),      32'd0);
    check("full_count",     32'(dut.u_fifo.o_count), 32'(DEPTH));
    check("hold_valid",     32'(bus.out_valid),     32'd1);
    check("hold_quotient",  32'(bus.out_quotient),  32'd22);
    check("hold_remainder", 32'(bus.out_remainder), 32'd2);
    check("hold_busy",      32'(bus.busy),          32'd1);
    bus.out_ready = 1'b1;
    push_op(8'd77, 8'd0, pk(8'hFF, 8'd77, 1'b1, 1'b0));
    drain(400);

    // Push and pop on the same edge with two entries queued
    bus.out_ready = 1'b0;
    push_op(8'd40, 8'd3, pk(8'd13, 8'd1, 1'b0, 1'b0));
    push_op(8'd50, 8'd5, pk(8'd10, 8'd0, 1'b0, 1'b0));
    push_op(8'd60, 8'd7, pk(8'd8,  8'd4, 1'b0, 1'b0));
    wait_valid(60);
    check("pp_count_before", 32'(dut.u_fifo.o_count), 32'd2);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check("pp_state_idle", 32'(dbg.state), 32'(IDLE));
    bus.in_x = 8'd70; bus.in_y = 8'd8; cur_exp = pk(8'd8, 8'd6, 1'b0, 1'b0);
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("pp_count_after", 32'(dut.u_fifo.o_count), 32'd2);
    check("pp_state_clr",   32'(dbg.state),          32'(CLR));
    drain(300);

    // Reset while the divider is running, with operands still queued
    push_op(8'd100, 8'd7, pk(8'd14, 8'd2, 1'b0, 1'b0));
    push_op(8'd20,  8'd3, pk(8'd6,  8'd2, 1'b0, 1'b0));
    push_op(8'd30,  8'd3, pk(8'd10, 8'd0, 1'b0, 1'b0));
    t = 0;
    while (dbg.state != WAIT && t < 40) begin @(posedge clk); #1; t++; end
    check("reached_wait", 32'(dbg.state), 32'(WAIT));
    reset = 1'b0;
    @(posedge clk); #1;
    exp_q.delete();
    check("mid_rst_state",     32'(dbg.state),         32'(IDLE));
    check("mid_rst_valid",     32'(bus.out_valid),     32'd0);
    check("mid_rst_div_reset", 32'(bus.div_reset),     32'd1);
    check("mid_rst_busy",      32'(bus.busy),          32'd0);
    check("mid_rst_in_ready",  32'(bus.in_ready),      32'd0);
    check("mid_rst_quotient",  32'(bus.out_quotient),  32'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    push_op(8'd9, 8'd4, pk(8'd2, 8'd1, 1'b0, 1'b0));
    drain(200);

    // Random stream with a randomly stalling consumer
    stream_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 25; i++) begin
          logic [N-1:0] rx;
          logic [N-1:0] ry;
          rx = N'($urandom_range(0, 255));
          ry = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom_range(1, 255));
          push_op(rx, ry, model(rx, ry));
          repeat ($urandom_range(0, 3)) @(posedge clk);
          #0;
        end
        stream_done = 1'b1;
      end
      begin
        while (!stream_done) begin
          @(posedge clk); #1;
          bus.out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    drain(3000);

`ifdef DIV_TIMEOUT_EN
    // Divider never finishes: abort after TIMEOUT WAIT cycles, then recover
    div_hang = 1'b1;
    push_op(8'd100, 8'd7, pk(8'd0, 8'd0, 1'b0, 1'b1));
    drain(TIMEOUT + 60);
    check("timeout_cleared", 32'(bus.out_timeout), 32'd0);
    div_hang = 1'b0;
    push_op(8'd9, 8'd4, pk(8'd2, 8'd1, 1'b0, 1'b0));
    drain(200);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
